// File: rtl/cnf_load_if.sv
// Load bus between the host literal stream, cnf_load_distributor and the per-core load ports.
// master: host stimulus and core readies; slave: the distributor itself.
interface cnf_load_if #(
  parameter int unsigned NUM_CORES = 4
) ();
  logic                 host_load_valid;
  logic [31:0]          host_load_literal;
  logic                 host_load_clause_end;
  logic                 host_load_ready;
  logic                 host_start;
  logic [NUM_CORES-1:0] core_load_valid;
  logic [31:0]          core_load_literal;
  logic                 core_load_clause_end;
  logic [NUM_CORES-1:0] core_load_ready;
  logic                 core_start;

  modport master (
    output host_load_valid, host_load_literal, host_load_clause_end, host_start, core_load_ready,
    input  host_load_ready, core_load_valid, core_load_literal, core_load_clause_end, core_start
  );

  modport slave (
    input  host_load_valid, host_load_literal, host_load_clause_end, host_start, core_load_ready,
    output host_load_ready, core_load_valid, core_load_literal, core_load_clause_end, core_start
  );
endinterface

// File: rtl/cnf_load_distributor.sv
// Buffers host DIMACS literals and delivers them to NUM_CORES clause load ports (broadcast or
// round-robin by clause). Optional open-clause check on host_start: CNF_LOAD_CLAUSE_CHECK_EN.
module cnf_load_distributor #(
  parameter int unsigned NUM_CORES            = 4,
  parameter int unsigned FIFO_DEPTH           = 8,
  parameter int unsigned MAX_VARS_PER_CORE    = 42,
  parameter int unsigned MAX_CLAUSES_PER_CORE = 104,
  parameter int unsigned MAX_LITS             = 416,
  parameter int unsigned MODE                 = 0
) (
  input  logic        clk,
  input  logic        rst,
  cnf_load_if.slave   bus,
  output logic        load_busy,
  output logic [31:0] clause_count,
  output logic [31:0] lit_count,
  output logic [31:0] max_var,
  output logic        err_bad_lit,
  output logic        err_overflow
);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TgtW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {StLoad, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [31:0]          lit_mem_q [FIFO_DEPTH];
  logic [31:0]          lit_mem_d [FIFO_DEPTH];
  logic                 ce_mem_q  [FIFO_DEPTH];
  logic                 ce_mem_d  [FIFO_DEPTH];
  logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [NUM_CORES-1:0] sent_q, sent_d;
  logic [TgtW-1:0]      tgt_q, tgt_d;
  // Core that receives the clause currently being pushed; fixed at 0 in broadcast mode.
  logic [TgtW-1:0]      push_tgt_q, push_tgt_d;
  logic [31:0]          core_cls_q [NUM_CORES];
  logic [31:0]          core_cls_d [NUM_CORES];
  logic [31:0]          core_lit_q [NUM_CORES];
  logic [31:0]          core_lit_d [NUM_CORES];
  logic [31:0]          lit_count_q, lit_count_d, clause_count_q, clause_count_d;
  logic [31:0]          max_var_q, max_var_d;
  logic                 err_bad_q, err_bad_d, err_ovf_q, err_ovf_d;
`ifdef CNF_LOAD_CLAUSE_CHECK_EN
  logic                 open_q, open_d;
`endif

  logic                 fifo_empty, fifo_full, xfer, lit_bad, push, pop;
  logic                 head_touched, last_unread, mark_prev, clause_inc, start_err;
  logic [31:0]          lit, lit_abs;
  logic                 ce;
  logic [NUM_CORES-1:0] accept;
  logic [PtrW-1:0]      last_ptr;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign lit        = bus.host_load_literal;
  assign ce         = bus.host_load_clause_end;
  assign last_ptr   = wptr_q - 1'b1;

  assign bus.core_load_literal    = lit_mem_q[rptr_q];
  assign bus.core_load_clause_end = ce_mem_q[rptr_q];
  assign load_busy    = !fifo_empty || (sent_q != '0);
  assign clause_count = clause_count_q;
  assign lit_count    = lit_count_q;
  assign max_var      = max_var_q;
  assign err_bad_lit  = err_bad_q;
  assign err_overflow = err_ovf_q;

  always_comb begin
    state_d        = state_q;
    lit_mem_d      = lit_mem_q;
    ce_mem_d       = ce_mem_q;
    wptr_d         = wptr_q;
    rptr_d         = rptr_q;
    count_d        = count_q;
    sent_d         = sent_q;
    tgt_d          = tgt_q;
    push_tgt_d     = push_tgt_q;
    core_cls_d     = core_cls_q;
    core_lit_d     = core_lit_q;
    lit_count_d    = lit_count_q;
    clause_count_d = clause_count_q;
    max_var_d      = max_var_q;
    err_bad_d      = err_bad_q;
    err_ovf_d      = err_ovf_q;
    start_err      = 1'b0;
    accept         = '0;
    pop            = 1'b0;
    bus.core_load_valid = '0;
    bus.core_start      = 1'b0;

    // Delivery side
    if (MODE == 0) begin
      bus.core_load_valid = fifo_empty ? '0 : ~sent_q;
      accept = bus.core_load_valid & bus.core_load_ready;
      pop    = !fifo_empty && ((sent_q | accept) == {NUM_CORES{1'b1}});
      sent_d = pop ? '0 : (sent_q | accept);
    end else begin
      if (!fifo_empty) bus.core_load_valid[tgt_q] = 1'b1;
      accept = bus.core_load_valid & bus.core_load_ready;
      pop    = |accept;
      if (pop && ce_mem_q[rptr_q]) begin
        tgt_d = (tgt_q == TgtW'(NUM_CORES - 1)) ? '0 : tgt_q + 1'b1;
      end
    end

    // Host side
    bus.host_load_ready = (state_q == StLoad) && !fifo_full;
    xfer    = bus.host_load_valid && bus.host_load_ready;
    lit_abs = lit[31] ? (32'd0 - lit) : lit;
    lit_bad = (lit == 32'd0) || (lit == 32'h8000_0000) || (lit_abs > 32'(MAX_VARS_PER_CORE));
    push    = xfer && !lit_bad;
    // The dropped literal's clause_end may only land on a tail entry no core has touched yet.
    head_touched = pop || (sent_q != '0) || (accept != '0);
    last_unread  = (count_q > CntW'(1)) || ((count_q == CntW'(1)) && !head_touched);
    mark_prev    = xfer && lit_bad && ce && last_unread;
    clause_inc   = (push && ce) || mark_prev;

    if (xfer && lit_bad) err_bad_d = 1'b1;
    if (push) begin
      lit_mem_d[wptr_q] = lit;
      ce_mem_d[wptr_q]  = ce;
      wptr_d            = wptr_q + 1'b1;
      if (lit_count_q != '1) lit_count_d = lit_count_q + 32'd1;
      if (lit_abs > max_var_q) max_var_d = lit_abs;
    end
    if (mark_prev) ce_mem_d[last_ptr] = 1'b1;
    if (clause_inc && clause_count_q != '1) clause_count_d = clause_count_q + 32'd1;
    if (pop) rptr_d = rptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (!push && pop) count_d = count_q - CntW'(1);

    // Per-core capacity accounting
    if (push && core_lit_q[push_tgt_q] >= 32'(MAX_LITS)) err_ovf_d = 1'b1;
    if (clause_inc && core_cls_q[push_tgt_q] >= 32'(MAX_CLAUSES_PER_CORE)) err_ovf_d = 1'b1;
    if (push && core_lit_q[push_tgt_q] != '1) begin
      core_lit_d[push_tgt_q] = core_lit_q[push_tgt_q] + 32'd1;
    end
    if (clause_inc && core_cls_q[push_tgt_q] != '1) begin
      core_cls_d[push_tgt_q] = core_cls_q[push_tgt_q] + 32'd1;
    end
    if (MODE != 0 && clause_inc) begin
      push_tgt_d = (push_tgt_q == TgtW'(NUM_CORES - 1)) ? '0 : push_tgt_q + 1'b1;
    end

`ifdef CNF_LOAD_CLAUSE_CHECK_EN
    open_d = open_q;
    if (push)           open_d = !ce;
    else if (mark_prev) open_d = 1'b0;
`endif

    case (state_q)
      StLoad: begin
        if (bus.host_start) begin
`ifdef CNF_LOAD_CLAUSE_CHECK_EN
          if (open_d) start_err = 1'b1;
          else        state_d = StDrain;
`else
          state_d = StDrain;
`endif
        end
      end
      StDrain: begin
        if (fifo_empty && sent_q == '0) begin
          bus.core_start = 1'b1;
          state_d        = StDone;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StLoad;
    endcase
    if (start_err) err_bad_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StLoad;
      lit_mem_q      <= '{default: '0};
      ce_mem_q       <= '{default: 1'b0};
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      sent_q         <= '0;
      tgt_q          <= '0;
      push_tgt_q     <= '0;
      core_cls_q     <= '{default: '0};
      core_lit_q     <= '{default: '0};
      lit_count_q    <= '0;
      clause_count_q <= '0;
      max_var_q      <= '0;
      err_bad_q      <= 1'b0;
      err_ovf_q      <= 1'b0;
`ifdef CNF_LOAD_CLAUSE_CHECK_EN
      open_q         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      lit_mem_q      <= lit_mem_d;
      ce_mem_q       <= ce_mem_d;
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
      sent_q         <= sent_d;
      tgt_q          <= tgt_d;
      push_tgt_q     <= push_tgt_d;
      core_cls_q     <= core_cls_d;
      core_lit_q     <= core_lit_d;
      lit_count_q    <= lit_count_d;
      clause_count_q <= clause_count_d;
      max_var_q      <= max_var_d;
      err_bad_q      <= err_bad_d;
      err_ovf_q      <= err_ovf_d;
`ifdef CNF_LOAD_CLAUSE_CHECK_EN
      open_q         <= open_d;
`endif
    end
  end
endmodule

// File: doc/cnf_load_distributor.md
Name: cnf_load_distributor

Overview:
- Host-side clause loader for multi-core satswarm grids; sits between the host literal stream and the per-core clause load ports.
- Buffers host literals in a FIFO and delivers them to NUM_CORES cores, either broadcast to every core or partitioned clause-by-clause round-robin.
- Counts literals and clauses and tracks the highest variable seen.
- Flags capacity overflow and malformed literals against per-core limits before the solve starts.

Parameters:
- NUM_CORES, 4, number of core load ports (≥1).
- FIFO_DEPTH, 8, literal buffer entries; power of 2, ≥2.
- MAX_VARS_PER_CORE, 42, largest legal |literal|.
- MAX_CLAUSES_PER_CORE, 104, clause capacity per core.
- MAX_LITS, 416, literal capacity per core.
- MODE, 0, 0 = broadcast, 1 = round-robin clause partition.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- host_load_valid  in  1  host literal valid
- host_load_literal  in  32  signed DIMACS literal
- host_load_clause_end  in  1  literal is last of clause
- host_load_ready  out  1  FIFO can accept
- host_start  in  1  host requests end of load / solve start
- core_load_valid  out  NUM_CORES  per-core literal valid
- core_load_literal  out  32  head literal (shared by all cores)
- core_load_clause_end  out  1  head clause_end (shared)
- core_load_ready  in  NUM_CORES  per-core accept
- core_start  out  1  one-cycle start pulse to all cores
- load_busy  out  1  FIFO non-empty or delivery in progress
- clause_count  out  32  clauses accepted from host
- lit_count  out  32  literals accepted from host
- max_var  out  32  max |literal| accepted
- err_bad_lit  out  1  sticky: zero literal or |lit| > MAX_VARS_PER_CORE
- err_overflow  out  1  sticky: per-core clause or literal capacity exceeded

Behaviour:
- Reset: FIFO empty; counters and max_var = 0; both err flags = 0; core_load_valid = 0; core_start = 0; host_load_ready = 1; FSM = LOAD; sent mask = 0; rr target = 0.
- FSM states:
  - LOAD: accepting literals. host_start → DRAIN.
  - DRAIN: host_load_ready = 0. When FIFO empty and sent mask clear → pulse core_start for 1 cycle → DONE.
  - DONE: holds; host_load_ready = 0; host_start ignored. Only rst leaves DONE.
- Host handshake:
  - Transfer occurs when host_load_valid && host_load_ready.
  - host_load_ready = (state == LOAD) && !fifo_full (registered count; no same-cycle pop bypass).
- Literal check, on each transfer:
  - Literal 0, or |lit| > MAX_VARS_PER_CORE: set err_bad_lit and drop the literal. If it carried clause_end, the clause_end is transferred onto the previous FIFO entry only when that entry is still unread; otherwise it is lost and err_bad_lit suffices.
  - Valid literal: push {lit, clause_end}; lit_count += 1; clause_count += clause_end; max_var = max(max_var, |lit|).
  - |lit| computed on the 32-bit two's-complement value; −2^31 is treated as bad.
- Capacity (per core):
  - Broadcast: the core load equals the totals.
  - Round-robin: a core's load is ceil of the share by target order; tracked with per-core clause and literal counters.
  - A push that would exceed MAX_CLAUSES_PER_CORE or MAX_LITS for its target core sets err_overflow; the literal is still pushed (core behaviour is then undefined; the host must check the flag).
- Delivery, broadcast (MODE = 0):
  - core_load_valid[i] = fifo_nonempty && !sent[i].
  - sent[i] sets on valid && ready for core i.
  - Pop the head when (sent | (valid & ready)) is all ones; clear sent in the same cycle.
  - First-word latency: push at cycle N → valid at N+1.
- Delivery, round-robin (MODE = 1):
  - Only core_load_valid[target] may assert.
  - Pop on that core's ready.
  - When a popped entry has clause_end, target advances (wraps NUM_CORES−1 → 0).
- Simultaneous push and pop on the same cycle: both occur; occupancy unchanged.
- host_start arriving together with a valid transfer in LOAD: the transfer is accepted, then the FSM enters DRAIN.
- rst mid-load or mid-delivery: all state is discarded and return to reset values; partially delivered clauses are not replayed.
- Counters saturate at 2^32−1.

Optional Feature:
- Macro: CNF_LOAD_CLAUSE_CHECK_EN.
- When defined:
  - Tracks an open-clause flag.
  - host_start while a clause is open (last accepted literal lacked clause_end) sets err_bad_lit.
  - The FSM stays in LOAD until the clause is closed, then honours a new host_start.
- When undefined: host_start is honoured unconditionally and any unterminated clause is delivered as-is.

Test Plan:
- MODE = 0, NUM_CORES = 4, load (1 −2 0)(3 0), all readies = 1 → each core sees 3 literals in order; clause_count = 2, lit_count = 3, max_var = 3; core_start pulses once after drain.
- MODE = 0, core 2 ready held low 10 cycles → FIFO fills to 8 and host_load_ready drops; no core sees a duplicate literal; order preserved after release.
- MODE = 1, NUM_CORES = 2, 5 clauses → cores get clauses {0, 2, 4} and {1, 3} respectively; target wraps to 0.
- Literal 43 with MAX_VARS_PER_CORE = 42, and literal 0 → err_bad_lit = 1; neither is delivered; lit_count unchanged.
- 105 one-literal clauses in MODE = 0 → err_overflow sets on the 105th push; clause_count = 105.
- rst asserted with 5 literals buffered → next cycle: FIFO empty, counters 0, core_load_valid = 0, host_load_ready = 1.
